// File: rtl/rs_issue_queue.sv
// ============================================================================
// Module   : rs_issue_queue
// Brief    : In-order two-operand reservation queue with CDB snoop/bypass.
//            Optional synchronous flush port enabled by defining RSQ_FLUSH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 2,
  parameter int TAG_BASE = 1
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [DATA_W-1:0]        in_data1,
  input  logic [DATA_W-1:0]        in_data2,
  input  logic [TAG_W-1:0]         in_tag1,
  input  logic [TAG_W-1:0]         in_tag2,
  output logic [TAG_W-1:0]         alloc_id,
  input  logic                     bc_en,
  input  logic [TAG_W-1:0]         bc_tag,
  input  logic [DATA_W-1:0]        bc_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [DATA_W-1:0]        out_data1,
  output logic [DATA_W-1:0]        out_data2,
  output logic [TAG_W-1:0]         out_id,
`ifdef RSQ_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0]   c_BASE  = TAG_W'(TAG_BASE);

  logic                 r_busy  [DEPTH];
  logic [OP_W-1:0]      r_op    [DEPTH];
  logic [TAG_W-1:0]     r_tag1  [DEPTH];
  logic [TAG_W-1:0]     r_tag2  [DEPTH];
  logic [DATA_W-1:0]    r_data1 [DEPTH];
  logic [DATA_W-1:0]    r_data2 [DEPTH];
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W:0]     r_count;

  logic w_flush;
  logic w_snoop;
  logic w_byp1;
  logic w_byp2;
  logic w_issue;
  logic w_write;

`ifdef RSQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Tag 0 means "ready", so a zero broadcast tag must never resolve anything.
  assign w_snoop   = bc_en && (bc_tag != '0);
  assign w_byp1    = w_snoop && (in_tag1 == bc_tag);
  assign w_byp2    = w_snoop && (in_tag2 == bc_tag);

  assign out_valid = r_busy[r_rd_ptr] && (r_tag1[r_rd_ptr] == '0) && (r_tag2[r_rd_ptr] == '0);
  assign out_op    = r_op[r_rd_ptr];
  assign out_data1 = r_data1[r_rd_ptr];
  assign out_data2 = r_data2[r_rd_ptr];
  assign out_id    = r_busy[r_rd_ptr] ? (c_BASE + TAG_W'(r_rd_ptr)) : '0;

  assign w_issue   = out_valid && out_ready;
  assign in_ready  = (r_count != c_FULL) || w_issue;
  assign w_write   = in_valid && in_ready;
  assign alloc_id  = c_BASE + TAG_W'(r_wr_ptr);
  assign count     = r_count;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_busy[k]  <= 1'b0;
        r_op[k]    <= '0;
        r_tag1[k]  <= '0;
        r_tag2[k]  <= '0;
        r_data1[k] <= '0;
        r_data2[k] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_busy[k]  <= 1'b0;
        r_op[k]    <= '0;
        r_tag1[k]  <= '0;
        r_tag2[k]  <= '0;
        r_data1[k] <= '0;
        r_data2[k] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_snoop && r_busy[k]) begin
          if (r_tag1[k] == bc_tag) begin
            r_tag1[k]  <= '0;
            r_data1[k] <= bc_data;
          end
          if (r_tag2[k] == bc_tag) begin
            r_tag2[k]  <= '0;
            r_data2[k] <= bc_data;
          end
        end
      end

      // Issue clear precedes the write so a full-queue write into the
      // just-freed head slot (rd_ptr == wr_ptr) wins.
      if (w_issue) begin
        r_busy[r_rd_ptr]  <= 1'b0;
        r_op[r_rd_ptr]    <= '0;
        r_tag1[r_rd_ptr]  <= '0;
        r_tag2[r_rd_ptr]  <= '0;
        r_data1[r_rd_ptr] <= '0;
        r_data2[r_rd_ptr] <= '0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end

      if (w_write) begin
        r_busy[r_wr_ptr]  <= 1'b1;
        r_op[r_wr_ptr]    <= in_op;
        r_tag1[r_wr_ptr]  <= w_byp1 ? '0 : in_tag1;
        r_tag2[r_wr_ptr]  <= w_byp2 ? '0 : in_tag2;
        r_data1[r_wr_ptr] <= w_byp1 ? bc_data : in_data1;
        r_data2[r_wr_ptr] <= w_byp2 ? bc_data : in_data2;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end

      if (w_write && !w_issue) begin
        r_count <= r_count + 1'b1;
      end else if (w_issue && !w_write) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
// ============================================================================
// Module   : tb_rs_issue_queue
// Brief    : Directed plus randomized bench for rs_issue_queue against a
//            queue-based reference model (flush exercised with RSQ_FLUSH_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rs_issue_queue;

  localparam int DEPTH    = 4;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int OP_W     = 2;
  localparam int TAG_BASE = 1;

  logic                   clk = 1'b0;
  logic                   nRST;
  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        in_op;
  logic [DATA_W-1:0]      in_data1;
  logic [DATA_W-1:0]      in_data2;
  logic [TAG_W-1:0]       in_tag1;
  logic [TAG_W-1:0]       in_tag2;
  logic [TAG_W-1:0]       alloc_id;
  logic                   bc_en;
  logic [TAG_W-1:0]       bc_tag;
  logic [DATA_W-1:0]      bc_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OP_W-1:0]        out_op;
  logic [DATA_W-1:0]      out_data1;
  logic [DATA_W-1:0]      out_data2;
  logic [TAG_W-1:0]       out_id;
  logic [$clog2(DEPTH):0] count;
`ifdef RSQ_FLUSH_EN
  logic                   flush;
`endif

  rs_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data1(in_data1), .in_data2(in_data2), .in_tag1(in_tag1), .in_tag2(in_tag2),
    .alloc_id(alloc_id),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_data1(out_data1), .out_data2(out_data2), .out_id(out_id),
`ifdef RSQ_FLUSH_EN
    .flush(flush),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    int                id;
  } ent_t;

  ent_t        q[$];
  int unsigned wcount = 0;
  int          total  = 0;
  int          bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mdl_valid();
    return (q.size() > 0) && (q[0].t1 == '0) && (q[0].t2 == '0);
  endfunction

  // Called at a negedge with inputs applied: compare, advance model, wait one cycle.
  task automatic tick();
    bit   exp_v, iss, wr, fl, snp;
    ent_t e;
    #1;
    exp_v = mdl_valid();
    chk("out_valid", out_valid, exp_v);
    chk("count", count, q.size());
    chk("in_ready", in_ready, (q.size() < DEPTH) || (exp_v && out_ready));
    chk("alloc_id", alloc_id, TAG_BASE + (wcount % DEPTH));
    if (exp_v) begin
      chk("out_op", out_op, q[0].op);
      chk("out_data1", out_data1, q[0].d1);
      chk("out_data2", out_data2, q[0].d2);
      chk("out_id", out_id, q[0].id);
    end
`ifdef RSQ_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    snp = bc_en && (bc_tag != '0);
    iss = exp_v && out_ready;
    wr  = in_valid && ((q.size() < DEPTH) || iss);
    if (fl) begin
      q.delete();
      wcount = 0;
    end else begin
      if (snp) begin
        foreach (q[i]) begin
          if (q[i].t1 == bc_tag) begin q[i].t1 = '0; q[i].d1 = bc_data; end
          if (q[i].t2 == bc_tag) begin q[i].t2 = '0; q[i].d2 = bc_data; end
        end
      end
      if (iss) void'(q.pop_front());
      if (wr) begin
        e.op = in_op;
        e.t1 = (snp && in_tag1 == bc_tag) ? '0 : in_tag1;
        e.d1 = (snp && in_tag1 == bc_tag) ? bc_data : in_data1;
        e.t2 = (snp && in_tag2 == bc_tag) ? '0 : in_tag2;
        e.d2 = (snp && in_tag2 == bc_tag) ? bc_data : in_data2;
        e.id = TAG_BASE + (wcount % DEPTH);
        q.push_back(e);
        wcount++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input int op, input int d1, input int d2,
                        input int t1, input int t2);
    in_valid = v;
    in_op    = OP_W'(op);
    in_data1 = DATA_W'(d1);
    in_data2 = DATA_W'(d2);
    in_tag1  = TAG_W'(t1);
    in_tag2  = TAG_W'(t2);
  endtask

  task automatic set_bc(input logic en, input int tag, input int data);
    bc_en   = en;
    bc_tag  = TAG_W'(tag);
    bc_data = DATA_W'(data);
  endtask

  initial begin
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    set_bc(0, 0, 0);
    out_ready = 1'b0;
`ifdef RSQ_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_alloc_id", alloc_id, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data1", out_data1, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_id", out_id, 0);
    @(negedge clk);
    nRST = 1'b1;

    // Basic ready write, issue next cycle.
    out_ready = 1'b1;
    set_in(1, 1, 5, 7, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    chk("basic_valid", out_valid, 1);
    chk("basic_d1", out_data1, 5);
    chk("basic_d2", out_data2, 7);
    chk("basic_id", out_id, 1);
    tick();

    // Broadcast resolves tag1 two cycles after write.
    set_in(1, 0, 0, 8, 3, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    chk("snoop_wait", out_valid, 0);
    tick();
    set_bc(1, 3, 'h99);
    tick();
    set_bc(0, 0, 0);
    chk("snoop_valid", out_valid, 1);
    chk("snoop_d1", out_data1, 'h99);
    tick();

    // Same-cycle bypass on tag2.
    set_in(1, 2, 1, 2, 0, 6);
    set_bc(1, 6, 'h42);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    set_bc(0, 0, 0);
    chk("bypass_valid", out_valid, 1);
    chk("bypass_d2", out_data2, 'h42);
    tick();

    // Fill, then simultaneous write and issue when full.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1, k, k + 10, k + 20, 0, 0);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    set_in(1, 3, 'hAA, 'hBB, 0, 0);
    tick();
    chk("full_swap_count", count, 4);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // In-order blocking: head waits on tag 2 while younger entry is ready.
    set_in(1, 1, 1, 2, 2, 0);
    tick();
    set_in(1, 2, 3, 4, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    chk("block_valid0", out_valid, 0);
    tick();
    chk("block_valid1", out_valid, 0);
    set_bc(1, 2, 'h11);
    tick();
    set_bc(0, 0, 0);
    chk("order_valid_a", out_valid, 1);
    chk("order_id_a", out_id, 1);
    chk("order_d1_a", out_data1, 'h11);
    tick();
    chk("order_valid_b", out_valid, 1);
    chk("order_id_b", out_id, 2);
    tick();

    // Wrap-around: 10 writes already done, so ids continue from slot 2.
    for (int k = 0; k < 10; k++) begin
      chk("wrap_alloc", alloc_id, ((k + 2) % 4) + 1);
      set_in(1, k, k * 3, k * 5, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) tick();

`ifdef RSQ_FLUSH_EN
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1, k, k, k, 0, 0);
      tick();
    end
    flush = 1'b1;
    set_in(1, 1, 9, 9, 0, 0);
    tick();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_alloc", alloc_id, 1);
`endif

    // Randomized traffic with one asynchronous reset in the middle.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        nRST = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_alloc", alloc_id, 1);
        q.delete();
        wcount = 0;
        #1;
        nRST = 1'b1;
      end
      set_in(($urandom % 3) != 0, $urandom, $urandom, $urandom,
             (($urandom % 3) == 0) ? $urandom_range(1, 15) : 0,
             (($urandom % 3) == 0) ? $urandom_range(1, 15) : 0);
      set_bc($urandom % 2, $urandom_range(0, 15), $urandom);
      out_ready = ($urandom % 4) != 0;
`ifdef RSQ_FLUSH_EN
      flush = ($urandom % 200) == 0;
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
